burst_line_memory: RTL and testbench

Parametrised line-granular backing memory behind the data cache. It serves whole cache-line reads (refill) and writes (write-back) over a `read`/`write`/`busywait` handshake, moving `BEAT_BYTES` bytes per cycle after a configurable initial latency. Geometry, beat width and latency are parameters, so different cache configurations and memory-speed models use the same block.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/beat_ram.sv | 27 ++
 rtl/burst_line_memory.sv | 121 ++++++++++++
 tb/tb_burst_line_memory.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the burst line memory: FSM state encoding and a
// width helper used to size counters and address buses.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ceiling log2 with a floor of one bit, so single-entry counters stay legal.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/beat_ram.sv
// Beat-wide storage array: single port, asynchronous read, synchronous write.
// Contents are never reset; simulation can preload them through the preload task.
module beat_ram #(
  parameter int WORDS  = 1024,
  parameter int WORD_W = 8,
  parameter int AW     = 10
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [WORDS];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

  task automatic preload(input int unsigned idx, input logic [WORD_W-1:0] value);
    if (idx < WORDS) r_mem[idx] = value;
  endtask

endmodule

// File: rtl/burst_line_memory.sv
// Line-granular backing memory: moves one cache line per request, one beat
// per cycle after an optional latency, over a read/write/busywait handshake.
module burst_line_memory
  import mem_pkg::*;
#(
  parameter int LINE_BYTES  = 16,
  parameter int BEAT_BYTES  = 1,
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 28,
  parameter int LAT         = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       address,
  input  logic [LINE_BYTES*8-1:0] writedata,
  output logic [LINE_BYTES*8-1:0] readdata,
  output logic                    busywait
);

  localparam int BEATS   = LINE_BYTES / BEAT_BYTES;
  localparam int LINES   = DEPTH_BYTES / LINE_BYTES;
  localparam int WORDS   = DEPTH_BYTES / BEAT_BYTES;
  localparam int LINE_W  = LINE_BYTES * 8;
  localparam int WORD_W  = BEAT_BYTES * 8;
  localparam int WORD_AW = clog2(WORDS);
  localparam int BEAT_W  = clog2(BEATS);
  localparam int LAT_W   = clog2((LAT > 0) ? LAT : 1);

  state_t              r_state, w_next;
  logic [BEAT_W-1:0]   r_beat;
  logic [LAT_W-1:0]    r_lat;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_lbuf;
  logic [LINE_W-1:0]   r_readdata;
  logic [LINE_W-1:0]   w_lbuf_next;
  logic                w_req;
  logic                w_last_beat;
  logic                w_lat_done;
  logic                w_we;
  logic [ADDR_W-1:0]   w_line;
  logic [WORD_AW-1:0]  w_word_addr;
  logic [WORD_W-1:0]   w_ram_wdata;
  logic [WORD_W-1:0]   w_ram_rdata;

  // Read and write together is treated as no request at all.
  assign w_req       = read ^ write;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_lat_done  = (r_lat == LAT_W'(LAT - 1));

  // Line index wraps modulo the number of stored lines; lines never straddle the wrap.
  assign w_line      = r_addr % ADDR_W'(LINES);
  assign w_word_addr = WORD_AW'(w_line) * WORD_AW'(BEATS) + WORD_AW'(r_beat);
  assign w_ram_wdata = r_wdata[r_beat*WORD_W +: WORD_W];
  assign w_we        = (r_state == ST_XFER) && w_req && r_op_wr;

  assign busywait = reset_n && w_req && (r_state != ST_DONE);
  assign readdata = r_readdata;

  always_comb begin
    w_lbuf_next = r_lbuf;
    w_lbuf_next[r_beat*WORD_W +: WORD_W] = w_ram_rdata;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req) w_next = (LAT > 0) ? ST_WAIT : ST_XFER;
      ST_WAIT: begin
        if (!w_req)          w_next = ST_IDLE;
        else if (w_lat_done) w_next = ST_XFER;
      end
      ST_XFER: begin
        if (!w_req)           w_next = ST_IDLE;
        else if (w_last_beat) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_lat      <= '0;
      r_readdata <= '0;
    end else begin
      r_state <= w_next;
      r_lat   <= (r_state == ST_WAIT && w_next == ST_WAIT) ? r_lat + 1'b1 : '0;
      r_beat  <= (r_state == ST_XFER && w_next == ST_XFER) ? r_beat + 1'b1 : '0;
      // The final beat bypasses the line buffer so readdata is complete on entering DONE.
      if (r_state == ST_XFER && w_req && w_last_beat && !r_op_wr)
        r_readdata <= w_lbuf_next;
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == ST_IDLE && w_req) begin
      r_addr  <= address;
      r_wdata <= writedata;
      r_op_wr <= write;
    end
    if (r_state == ST_XFER) r_lbuf <= w_lbuf_next;
  end

  beat_ram #(
    .WORDS  (WORDS),
    .WORD_W (WORD_W),
    .AW     (WORD_AW)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_we),
    .i_addr  (w_word_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_burst_line_memory.sv
// Bench for burst_line_memory: a default-geometry instance and a 4-byte-beat,
// 3-cycle-latency instance sharing one clock and reset.
module tb_burst_line_memory;

  localparam logic [127:0] LA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LB = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] LC = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
  localparam logic [127:0] LD = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] LM = 128'hDEADBEEFCAFEF00D1234560403020100;
  localparam logic [127:0] LE = 128'hFFEEDDCCBBAA99887766554433221100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         rd0, wr0, busy0, rd1, wr1, busy1;
  logic [27:0]  addr0, addr1;
  logic [127:0] wd0, rdat0, wd1, rdat1;

  burst_line_memory u0 (
    .clock(clk), .reset_n(reset_n), .read(rd0), .write(wr0), .address(addr0),
    .writedata(wd0), .readdata(rdat0), .busywait(busy0)
  );

  burst_line_memory #(.BEAT_BYTES(4), .LAT(3)) u1 (
    .clock(clk), .reset_n(reset_n), .read(rd1), .write(wr1), .address(addr1),
    .writedata(wd1), .readdata(rdat1), .busywait(busy1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    int           busy;
    logic [127:0] rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: counts busy cycles (bounded) and returns readdata seen in DONE.
  task automatic txn(input int inst, input logic wr, input logic [27:0] a,
                     input logic [127:0] wd, output int n, output logic [127:0] rd);
    n = 0;
    @(posedge clk); #1;
    if (inst == 0) begin rd0 = ~wr; wr0 = wr; addr0 = a; wd0 = wd; end
    else           begin rd1 = ~wr; wr1 = wr; addr1 = a; wd1 = wd; end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((inst == 0) ? busy0 : busy1) n++;
      else break;
    end
    rd = (inst == 0) ? rdat0 : rdat1;
    @(posedge clk); #1;
    if (inst == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
    else           begin rd1 = 1'b0; wr1 = 1'b0; end
  endtask

  initial begin
    int n;
    logic [127:0] rd;

    reset_n = 1'b0;
    rd0 = 0; wr0 = 0; addr0 = '0; wd0 = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wd1 = '0;
    #12;
    rd0 = 1'b1;
    #1;
    chk("reset_busy_forced", {127'd0, busy0}, 128'd0);
    chk("reset_rdata0", rdat0, 128'd0);
    chk("reset_rdata1", rdat1, 128'd0);
    rd0 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Wide-beat instance with latency.
    txn(1, 1'b1, 28'd7, LE, n, rd);
    chk("u1_wr_busy", 128'(n), 128'd8);
    chk("u1_wr_rdata_held", rd, 128'd0);
    txn(1, 1'b0, 28'd7, '0, n, rd);
    chk("u1_rd_busy", 128'(n), 128'd8);
    chk("u1_rd_data", rd, LE);
    chk("u1_byte0_low", {96'd0, rd[31:0]}, 128'h33221100);

    vecs[0] = '{1'b1, 28'd3,  LA,  17, 128'd0};
    vecs[1] = '{1'b0, 28'd3,  '0,  17, LA};
    vecs[2] = '{1'b1, 28'd2,  LB,  17, LA};
    vecs[3] = '{1'b0, 28'd66, '0,  17, LB};
    vecs[4] = '{1'b1, 28'd69, LC,  17, LB};
    vecs[5] = '{1'b0, 28'd5,  '0,  17, LC};
    vecs[6] = '{1'b0, 28'd3,  '0,  17, LA};
    for (int i = 0; i < 7; i++) begin
      txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, n, rd);
      chk($sformatf("vec%0d_busy", i), 128'(n), 128'(vecs[i].busy));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
    end

    // read and write together: no request, nothing changes.
    @(posedge clk); #1;
    rd0 = 1'b1; wr0 = 1'b1; addr0 = 28'd3; wd0 = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("both_busy%0d", i), {127'd0, busy0}, 128'd0);
    end
    chk("both_rdata_held", rdat0, LA);
    @(posedge clk); #1;
    rd0 = 1'b0; wr0 = 1'b0;
    txn(0, 1'b0, 28'd3, '0, n, rd);
    chk("both_mem_busy", 128'(n), 128'd17);
    chk("both_mem_data", rd, LA);

    // Abort a write after five beats, then read immediately.
    @(posedge clk); #1;
    wr0 = 1'b1; rd0 = 1'b0; addr0 = 28'd5; wd0 = LD;
    repeat (6) @(posedge clk);
    #1 wr0 = 1'b0;
    txn(0, 1'b0, 28'd5, '0, n, rd);
    chk("abort_idle_busy", 128'(n), 128'd17);
    chk("abort_partial", rd, LM);

    // Reset in the middle of a read.
    @(posedge clk); #1;
    rd0 = 1'b1; addr0 = 28'd3;
    repeat (4) @(posedge clk);
    #2;
    chk("midrd_busy_before", {127'd0, busy0}, 128'd1);
    reset_n = 1'b0;
    #1;
    chk("midrd_rst_busy", {127'd0, busy0}, 128'd0);
    chk("midrd_rst_rdata", rdat0, 128'd0);
    rd0 = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    txn(0, 1'b0, 28'd2, '0, n, rd);
    chk("post_rst_busy", 128'(n), 128'd17);
    chk("post_rst_data", rd, LB);
    txn(0, 1'b0, 28'd5, '0, n, rd);
    chk("post_rst_mem_kept", rd, LM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
